dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 126 ++++++++++++
 tb/tb_dmem_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Single-port data memory with a request/stall/ack handshake and programmable wait states.
// Optional macro DMEM_MMIO_EN adds a byte-writable mmio_out register mapped at addr[31]=1.
module dmem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_ack
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateType;

    localparam int             WORDS     = 1 << DEPTH_LOG2;
    localparam logic [2:0]     WAIT_INIT = 3'(WAIT_CYCLES);

    stateType                  state;
    logic [2:0]                waitCnt;
    logic                      reqWe;
    logic [DEPTH_LOG2-1:0]     reqIdx;
    logic [31:0]               reqWdata;
    logic [3:0]                reqBe;
    logic                      commit;
    logic                      ramWe;
    logic [31:0]               ram [WORDS];

    // Byte offset and bits above the RAM index are ignored, so addresses alias.
    logic unusedAddr;
    assign unusedAddr = ^{mem_addr[1:0], mem_addr[31:DEPTH_LOG2+2]};

    assign commit    = (state == BUSY) && (waitCnt == 3'd0);
    assign mem_stall = ((state == IDLE) && mem_req) || (state == BUSY);

`ifdef DMEM_MMIO_EN
    logic reqMmio;
    assign ramWe = commit && reqWe && !reqMmio && !rst;
`else
    assign ramWe = commit && reqWe && !rst;
`endif

    // NOTE: the RAM array has no reset; contents survive rst and only the control path is cleared.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (reqBe[i]) begin
                    ram[reqIdx][8*i +: 8] <= reqWdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= 3'd0;
            mem_ack   <= 1'b0;
            mem_rdata <= 32'h0;
`ifdef DMEM_MMIO_EN
            mmio_out  <= 32'h0;
`endif
        end else begin
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        reqWe    <= mem_we;
                        reqIdx   <= mem_addr[DEPTH_LOG2+1:2];
                        reqWdata <= mem_wdata;
                        reqBe    <= mem_be;
`ifdef DMEM_MMIO_EN
                        reqMmio  <= mem_addr[31];
`endif
                        waitCnt  <= WAIT_INIT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (waitCnt == 3'd0) begin
`ifdef DMEM_MMIO_EN
                        if (!reqWe) begin
                            mem_rdata <= reqMmio ? mmio_out : ram[reqIdx];
                        end else if (reqMmio) begin
                            for (int i = 0; i < 4; i++) begin
                                if (reqBe[i]) begin
                                    mmio_out[8*i +: 8] <= reqWdata[8*i +: 8];
                                end
                            end
                        end
`else
                        if (!reqWe) begin
                            mem_rdata <= ram[reqIdx];
                        end
`endif
                        mem_ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances with WAIT_CYCLES 1, 0 and 7,
// directed vector table, reset/back-to-back sequences and randomized traffic vs a word-array model.
module tb_dmem_resp;

    localparam int NU = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vecType;

    logic        clk;
    logic        rst;
    logic        req   [NU];
    logic        we    [NU];
    logic [31:0] addr  [NU];
    logic [31:0] wdata [NU];
    logic [3:0]  be    [NU];
    logic [31:0] rdata [NU];
    logic        stall [NU];
    logic        ack   [NU];
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio  [NU];
    logic [31:0] modelMmio [NU];
`endif

    logic [31:0] model     [NU][1024];
    logic [31:0] modelRdata[NU];

    int nChecks = 0;
    int nPass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : gUnit
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 7);
        dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
            .clk       (clk),
            .rst       (rst),
            .mem_req   (req[g]),
            .mem_we    (we[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_be    (be[g]),
            .mem_rdata (rdata[g]),
            .mem_stall (stall[g]),
            .mem_ack   (ack[g])
`ifdef DMEM_MMIO_EN
            ,
            .mmio_out  (mmio[g])
`endif
        );
    end

    function automatic int waitOf(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 0 : 7);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One complete transaction on unit u; checks handshake timing and updates the model.
    task automatic access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd);
        int lat;
        int stl;
        bit got;
        int idx;
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
        #1;
        check("accept_stall", 32'(stall[u]), 32'd1);
        lat = 0; stl = 0; got = 1'b0;
        while (!got && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (ack[u]) got = 1'b1;
            else if (stall[u]) stl++;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        check("ack_latency", 32'(lat), 32'(waitOf(u) + 2));
        check("busy_stall_cycles", 32'(stl), 32'(waitOf(u) + 1));
        check("done_stall", 32'(stall[u]), 32'd0);
        rd = rdata[u];
        req[u] = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack[u]), 32'd0);
        check("rdata_hold", rdata[u], rd);
        idx = int'(a[11:2]);
`ifdef DMEM_MMIO_EN
        if (a[31]) begin
            if (w) modelMmio[u] = merge(modelMmio[u], d, b);
            else   modelRdata[u] = modelMmio[u];
        end else
`endif
        begin
            if (w) model[u][idx] = merge(model[u][idx], d, b);
            else   modelRdata[u] = model[u][idx];
        end
    endtask

    vecType      vecs [10];
    logic [31:0] rd;
    int          acks;
    int          lat;

    initial begin
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            req[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdata[u] = '0; be[u] = '0;
            modelRdata[u] = 32'h0;
`ifdef DMEM_MMIO_EN
            modelMmio[u] = 32'h0;
`endif
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        req[0] = 1'b1; #1;
        check("stall_in_reset", 32'(stall[0]), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < NU; u++) begin
            check("reset_rdata", rdata[u], 32'h0);
            check("reset_ack", 32'(ack[u]), 32'd0);
            check("reset_stall", 32'(stall[u]), 32'd0);
`ifdef DMEM_MMIO_EN
            check("reset_mmio", mmio[u], 32'h0);
`endif
        end

        // Directed vectors on the WAIT_CYCLES=1 unit; exp is mem_rdata after the access.
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_AAEF};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'hDEAD_AAEF};
        vecs[5] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_AAEF};
        vecs[6] = '{1'b1, 32'h0000_0024, 32'h0123_4567, 4'hF, 32'hDEAD_AAEF};
        vecs[7] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h9, 32'hDEAD_AAEF};
        vecs[8] = '{1'b0, 32'h7FFF_F024, 32'h0,         4'hF, 32'hCA23_450D};
        vecs[9] = '{1'b0, 32'h0000_1010, 32'h0,         4'hF, 32'hDEAD_AAEF};
        for (int i = 0; i < 10; i++) begin
            access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Aliasing with zero wait states.
        access(1, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, rd);
        access(1, 1'b0, 32'h0000_0004, 32'h0, 4'hF, rd);
        check("alias_rdata", rd, 32'h1234_5678);

`ifdef DMEM_MMIO_EN
        access(1, 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, rd);
        access(1, 1'b1, 32'h8000_0000, 32'h0000_00A5, 4'hF, rd);
        check("mmio_write", mmio[1], 32'h0000_00A5);
        access(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, rd);
        check("mmio_ram_untouched", rd, 32'h1122_3344);
        access(1, 1'b1, 32'h8000_0004, 32'h0000_7700, 4'h2, rd);
        check("mmio_byte_write", mmio[1], 32'h0000_77A5);
        access(1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd);
        check("mmio_read", rd, 32'h0000_77A5);
`else
        access(1, 1'b1, 32'h8000_0008, 32'h5A5A_5A5A, 4'hF, rd);
        access(1, 1'b0, 32'h0000_0008, 32'h0, 4'hF, rd);
        check("addr31_ignored", rd, 32'h5A5A_5A5A);
`endif

        // Reset on the commit edge of a write discards it and suppresses the ack.
        access(0, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, rd);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hFFFF_FFFF; be[0] = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_no_ack", 32'(ack[0]), 32'd0);
        check("rst_stall", 32'(stall[0]), 32'd0);
        for (int u = 0; u < NU; u++) begin
            check("rst_rdata_clear", rdata[u], 32'h0);
            modelRdata[u] = 32'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
        end
        check("rst_abandon_acks", 32'(acks), 32'd0);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, rd);
        check("rst_write_discarded", rd, 32'h0);

        // Back-to-back reads with mem_req held high through DONE.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'hF;
        lat = 0;
        while (!ack[0] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'd3);
        check("b2b_first_rdata", rdata[0], 32'hDEAD_AAEF);
        check("b2b_done_stall", 32'(stall[0]), 32'd0);
        addr[0] = 32'h24;
        @(posedge clk); #1;
        check("b2b_idle_ack", 32'(ack[0]), 32'd0);
        check("b2b_idle_stall", 32'(stall[0]), 32'd1);
        lat = 0;
        while (!ack[0] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'd3);
        check("b2b_second_rdata", rdata[0], 32'hCA23_450D);
        req[0] = 1'b0;
        acks = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
        end
        check("b2b_no_extra_ack", 32'(acks), 32'd0);
        modelRdata[0] = 32'hCA23_450D;

        // Randomized traffic over a pool of word indices, compared with the model.
        for (int u = 0; u < NU; u++) begin
            for (int k = 0; k < 8; k++) begin
                access(u, 1'b1, 32'(k * 37 * 4), $urandom, 4'hF, rd);
                check("rand_init_rdata", rd, modelRdata[u]);
            end
            for (int n = 0; n < 50; n++) begin
                logic [31:0] a;
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 7) * 37);
`ifdef DMEM_MMIO_EN
                a[31] = 1'b0;
`endif
                access(u, 1'($urandom), a, $urandom, 4'($urandom), rd);
                check("rand_rdata", rd, modelRdata[u]);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
